// File: rtl/i2s_mic_rx_pkg.sv
// Shared audio constants for the I2S capture and playback paths.
// Both directions use the same divider taps so their frame timing matches.
package i2s_mic_rx_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int AUDIO_CNT_W    = 9;

    localparam logic [3:0] CAPTURE_PHASE = 4'hA;
    localparam int LRCK_BIT = 8;
    localparam int SCK_BIT  = 3;
    localparam int MCLK_BIT = 1;

    // The LSB arrives in slot 0 of the following half; append it to the 15 shifted bits.
    function automatic logic [AUDIO_SAMPLE_W-1:0] complete_word(
        input logic [AUDIO_SAMPLE_W-2:0] shifted,
        input logic                      lsb
    );
        return {shifted, lsb};
    endfunction

endpackage

// File: rtl/i2s_mic_rx_if.sv
// I2S pin bundle plus the published stereo-sample bus of the capture path.
// master = the receiver/clock owner, slave = the ADC and sample consumer side.
interface i2s_mic_rx_if #(
    parameter int SAMPLE_W = 16
);
    logic                MCLK;
    logic                SCK;
    logic                LRCK;
    logic                SDIN;
    logic [SAMPLE_W-1:0] left_sample;
    logic [SAMPLE_W-1:0] right_sample;
    logic                sample_valid;

    modport master (
        output MCLK, SCK, LRCK, left_sample, right_sample, sample_valid,
        input  SDIN
    );

    modport slave (
        input  MCLK, SCK, LRCK, left_sample, right_sample, sample_valid,
        output SDIN
    );
endinterface

// File: rtl/i2s_mic_rx_clk_gen.sv
// Frame divider for I2S: en-gated counter with registered MCLK/SCK/LRCK taps.
// Taps are loaded from the next count so they never lag the exported counter.
module i2s_clk_gen
    import i2s_mic_rx_pkg::*;
#(
    parameter int CNT_W = AUDIO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             mclk,
    output logic             sck,
    output logic             lrck
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mclk_q, mclk_d;
    logic             sck_q, sck_d;
    logic             lrck_q, lrck_d;

    always_comb begin
        cnt_d  = en ? cnt_q + 1'b1 : '0;
        mclk_d = cnt_d[MCLK_BIT];
        sck_d  = cnt_d[SCK_BIT];
        lrck_d = cnt_d[LRCK_BIT];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            mclk_q <= 1'b0;
            sck_q  <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mclk_q <= mclk_d;
            sck_q  <= sck_d;
            lrck_q <= lrck_d;
        end
    end

    assign cnt  = cnt_q;
    assign mclk = mclk_q;
    assign sck  = sck_q;
    assign lrck = lrck_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: generates the I2S clocks, deserializes SDIN into 16-bit
// left/right words and publishes each stereo pair with a one-cycle strobe.
module i2s_mic_rx
    import i2s_mic_rx_pkg::*;
#(
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int CNT_W    = AUDIO_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    i2s_mic_rx_if.master bus
);

    logic [CNT_W-1:0]    cnt;
    logic                mclk, sck, lrck;
    logic [3:0]          slot;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [SAMPLE_W-2:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_stage_q, left_stage_d;
    logic [SAMPLE_W-1:0] left_sample_q, left_sample_d;
    logic [SAMPLE_W-1:0] right_sample_q, right_sample_d;
    logic                valid_q, valid_d;
    logic                primed_q, primed_d;
    logic [SAMPLE_W-1:0] word;

    i2s_clk_gen #(.CNT_W(CNT_W)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt),
        .mclk (mclk),
        .sck  (sck),
        .lrck (lrck)
    );

    assign slot = cnt[LRCK_BIT-1:SCK_BIT+1];
    assign word = complete_word(shift_q, sync2_q);

    always_comb begin
        sync1_d        = bus.SDIN;
        sync2_d        = sync1_q;
        shift_d        = shift_q;
        left_stage_d   = left_stage_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        primed_d       = primed_q;
        valid_d        = 1'b0;

        if (!en) begin
            // Drop any partial frame; published samples are kept.
            shift_d      = '0;
            left_stage_d = '0;
            primed_d     = 1'b0;
        end else begin
            if (cnt == {CNT_W{1'b1}}) begin
                primed_d = 1'b1;
            end
            if (cnt[3:0] == CAPTURE_PHASE) begin
                if (slot != 4'd0) begin
                    shift_d = {shift_q[SAMPLE_W-3:0], sync2_q};
                end else if (cnt[LRCK_BIT]) begin
                    left_stage_d = word;
                end else if (primed_q) begin
                    // Right LSB just arrived: the pair is visible during cnt=0x00B.
                    left_sample_d  = left_stage_q;
                    right_sample_d = word;
                    valid_d        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            shift_q        <= '0;
            left_stage_q   <= '0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            valid_q        <= 1'b0;
            primed_q       <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            shift_q        <= shift_d;
            left_stage_q   <= left_stage_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            valid_q        <= valid_d;
            primed_q       <= primed_d;
        end
    end

    assign bus.MCLK         = mclk;
    assign bus.SCK          = sck;
    assign bus.LRCK         = lrck;
    assign bus.left_sample  = left_sample_q;
    assign bus.right_sample = right_sample_q;
    assign bus.sample_valid = valid_q;

endmodule
